// File: rtl/note_cmd_unit.sv
// ============================================================================
// Module      : note_cmd_unit
// Description : Decodes write_32 command words into tone period, gate and
//               envelope pulses, with tick-paced glide between notes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_cmd_unit #(
    parameter int unsigned TICK_DIV_RST = 1000
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] cmd_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [22:0] period,
    output logic        gate,
    output logic        note_on,
    output logic        note_off,
    output logic        bad_cmd
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_GLIDE  = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_NOTE  = 4'h0;
    localparam logic [3:0] c_OP_GLIDE = 4'h1;
    localparam logic [3:0] c_OP_TICK  = 4'h2;

    state_t      r_state, w_state_nxt;
    logic        r_ready;
    logic [3:0]  r_op;
    logic [22:0] r_arg;
    logic        r_from_glide;
    logic [22:0] r_period, r_target;
    logic        r_gate, r_note_on, r_note_off, r_bad_cmd;
    logic [15:0] r_step;
    logic [19:0] r_div, r_cnt;

    logic        w_accept, w_tick, w_unused;
    logic [19:0] w_div_eff, w_tick_last;
    logic [22:0] w_diff, w_move, w_glide_period, w_period_cur;
    logic [22:0] w_d_period, w_d_target;
    logic        w_d_gate, w_d_on, w_d_off, w_d_bad;
    logic [15:0] w_d_step;
    logic [19:0] w_d_div;

    assign w_unused    = ^cmd_data[27:23];
    assign w_accept    = cmd_valid & r_ready;
    assign w_div_eff   = (r_div == 20'd0) ? 20'd1 : r_div;
    assign w_tick_last = w_div_eff - 20'd1;
    // >= rather than == so a tick_div shrunk mid-glide still wraps promptly
    assign w_tick      = (r_state == S_GLIDE) && (r_cnt >= w_tick_last);

    assign w_diff         = (r_period < r_target) ? (r_target - r_period) : (r_period - r_target);
    assign w_move         = ({7'd0, r_step} < w_diff) ? {7'd0, r_step} : w_diff;
    assign w_glide_period = (r_period < r_target) ? (r_period + w_move) : (r_period - w_move);
    assign w_period_cur   = w_tick ? w_glide_period : r_period;

    always_comb begin
        w_d_period = r_period;
        w_d_target = r_target;
        w_d_gate   = r_gate;
        w_d_on     = 1'b0;
        w_d_off    = 1'b0;
        w_d_bad    = 1'b0;
        w_d_step   = r_step;
        w_d_div    = r_div;
        case (r_op)
            c_OP_NOTE: begin
                if (r_arg != 23'd0) begin
                    w_d_target = r_arg;
                    if (!r_gate) begin
                        w_d_period = r_arg;
                        w_d_gate   = 1'b1;
                        w_d_on     = 1'b1;
                    end else if (r_step == 16'd0) begin
                        w_d_period = r_arg;
                    end
                end else if (r_gate) begin
                    // release keeps sounding at the current pitch
                    w_d_gate   = 1'b0;
                    w_d_off    = 1'b1;
                    w_d_target = r_period;
                end
            end
            c_OP_GLIDE: w_d_step = r_arg[15:0];
            c_OP_TICK:  w_d_div  = r_arg[19:0];
            default:    w_d_bad  = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                w_state_nxt = (w_d_period != w_d_target) ? S_GLIDE : S_IDLE;
            end
            S_GLIDE: begin
                if (w_accept)                        w_state_nxt = S_DECODE;
                else if (w_period_cur == r_target)   w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_op         <= 4'd0;
            r_arg        <= 23'd0;
            r_from_glide <= 1'b0;
            r_period     <= 23'd0;
            r_target     <= 23'd0;
            r_gate       <= 1'b0;
            r_note_on    <= 1'b0;
            r_note_off   <= 1'b0;
            r_bad_cmd    <= 1'b0;
            r_step       <= 16'd0;
            r_div        <= 20'(TICK_DIV_RST);
            r_cnt        <= 20'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready    <= (w_state_nxt != S_DECODE);
            r_note_on  <= 1'b0;
            r_note_off <= 1'b0;
            r_bad_cmd  <= 1'b0;
            if (w_accept) begin
                r_op         <= cmd_data[31:28];
                r_arg        <= cmd_data[22:0];
                r_from_glide <= (r_state == S_GLIDE);
            end
            if (r_state == S_GLIDE) begin
                if (w_tick) begin
                    r_cnt    <= 20'd0;
                    r_period <= w_glide_period;
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                end
            end
            if (r_state == S_DECODE) begin
                r_period   <= w_d_period;
                r_target   <= w_d_target;
                r_gate     <= w_d_gate;
                r_note_on  <= w_d_on;
                r_note_off <= w_d_off;
                r_bad_cmd  <= w_d_bad;
                r_step     <= w_d_step;
                r_div      <= w_d_div;
                // a retarget mid-glide keeps the tick phase running
                if (!r_from_glide) r_cnt <= 20'd0;
            end
        end
    end

    assign cmd_ready = r_ready;
    assign period    = r_period;
    assign gate      = r_gate;
    assign note_on   = r_note_on;
    assign note_off  = r_note_off;
    assign bad_cmd   = r_bad_cmd;

endmodule

`default_nettype wire

// File: tb/tb_note_cmd_unit.sv
// ============================================================================
// Module      : tb_note_cmd_unit
// Description : Directed and randomized checks of note_cmd_unit against a
//               behavioural note/glide model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_cmd_unit;

    localparam int unsigned c_TICK_DIV_RST = 1000;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [22:0] period;
    logic        gate, note_on, note_off, bad_cmd;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    int unsigned m_period, m_target, m_step, m_div;
    bit          m_gate, m_on, m_off, m_bad;

    note_cmd_unit #(.TICK_DIV_RST(c_TICK_DIV_RST)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .period    (period),
        .gate      (gate),
        .note_on   (note_on),
        .note_off  (note_off),
        .bad_cmd   (bad_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_period = 0; m_target = 0; m_step = 0; m_div = c_TICK_DIV_RST;
        m_gate = 0; m_on = 0; m_off = 0; m_bad = 0;
    endtask

    task automatic model_apply(input logic [31:0] w);
        int unsigned n;
        n = w[22:0];
        m_on = 0; m_off = 0; m_bad = 0;
        case (w[31:28])
            4'h0: begin
                if (n != 0) begin
                    m_target = n;
                    if (!m_gate) begin
                        m_period = n; m_gate = 1; m_on = 1;
                    end else if (m_step == 0) begin
                        m_period = n;
                    end
                end else if (m_gate) begin
                    m_gate = 0; m_off = 1; m_target = m_period;
                end
            end
            4'h1: m_step = w[15:0];
            4'h2: m_div  = w[19:0];
            default: m_bad = 1;
        endcase
    endtask

    task automatic model_glide_tick();
        int unsigned d, mv;
        d  = (m_target > m_period) ? m_target - m_period : m_period - m_target;
        mv = (m_step < d) ? m_step : d;
        if (m_target > m_period) m_period = m_period + mv;
        else                     m_period = m_period - mv;
    endtask

    // wait for ready, then take the accept edge
    task automatic send(input logic [31:0] w);
        int guard;
        guard = 0;
        cmd_data  = w;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'd0, 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("ready_in_decode", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic do_cmd(input logic [31:0] w);
        int unsigned d_eff, c;
        model_apply(w);
        send(w);
        step();
        chk("period_apply", {9'd0, period}, m_period);
        chk("gate_apply", {31'd0, gate}, {31'd0, m_gate});
        chk("note_on", {31'd0, note_on}, {31'd0, m_on});
        chk("note_off", {31'd0, note_off}, {31'd0, m_off});
        chk("bad_cmd", {31'd0, bad_cmd}, {31'd0, m_bad});
        d_eff = (m_div == 0) ? 1 : m_div;
        c = 0;
        while (m_period != m_target) begin
            step();
            c++;
            if (c % d_eff == 0) model_glide_tick();
            chk("glide_period", {9'd0, period}, m_period);
            if (note_on || note_off || bad_cmd)
                chk("glide_pulses", {29'd0, note_on, note_off, bad_cmd}, 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_period", {9'd0, period}, m_period);
            chk("hold_pulses", {29'd0, note_on, note_off, bad_cmd}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_cmd();
        int unsigned r;
        logic [31:0] w;
        r = $urandom_range(0, 9);
        w = 32'd0;
        if (r <= 4) begin
            w[27:23] = 5'($urandom);
            w[22:0]  = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom_range(100, 400));
        end else if (r <= 6) begin
            w[31:28] = 4'h1;
            w[15:0]  = 16'($urandom_range(0, 40));
        end else if (r == 7) begin
            w[31:28] = 4'h2;
            w[19:0]  = 20'($urandom_range(0, 6));
        end else if (r == 8) begin
            w        = $urandom;
            w[31:28] = 4'($urandom_range(3, 15));
        end
        return w;
    endfunction

    initial begin
        logic [31:0] b2b [3];
        model_reset();
        repeat (3) step();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_period", {9'd0, period}, 32'd0);
        chk("rst_outs", {28'd0, gate, note_on, note_off, bad_cmd}, 32'd0);
        rst_b = 1'b1;
        step();
        chk("ready_first_edge", {31'd0, cmd_ready}, 32'd1);

        do_cmd(32'h0000_0100);
        do_cmd(32'h1000_0020);
        do_cmd(32'h0000_0120);          // one glide tick at the reset divider
        do_cmd(32'h1000_0000);
        do_cmd(32'd100);
        do_cmd(32'h1000_000A);
        do_cmd(32'h2000_0004);
        do_cmd(32'd125);                // 110, 120, 125 at 4-cycle spacing
        do_cmd(32'h0000_0000);
        do_cmd(32'h0000_0000);
        do_cmd(32'h7123_4567);
        do_cmd(32'd50);
        do_cmd(32'd80);                 // config survived the bad opcode

        b2b[0] = 32'h1000_0000; b2b[1] = 32'h0000_0200; b2b[2] = 32'h0000_0300;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_data = b2b[i];
            model_apply(b2b[i]);
            chk("b2b_ready_hi", {31'd0, cmd_ready}, 32'd1);
            step();
            chk("b2b_ready_lo", {31'd0, cmd_ready}, 32'd0);
            step();
            chk("b2b_period", {9'd0, period}, m_period);
        end
        cmd_valid = 1'b0;
        step();

        for (int k = 0; k < 40; k++) do_cmd(rand_cmd());

        do_cmd(32'h0000_0000);
        do_cmd(32'd200);
        do_cmd(32'h1000_0005);
        do_cmd(32'h2000_0003);
        send(32'd400);
        repeat (7) step();
        rst_b = 1'b0;
        #1;
        chk("midrst_period", {9'd0, period}, 32'd0);
        chk("midrst_outs", {28'd0, gate, note_on, note_off, bad_cmd}, 32'd0);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("midrst_hold", {27'd0, cmd_ready, gate, note_on, note_off, bad_cmd}, 32'd0);
        rst_b = 1'b1;
        model_reset();
        step();
        chk("postrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("postrst_outs", {5'd0, period, gate, note_on, note_off, bad_cmd}, 32'd0);
        do_cmd(32'h0000_0100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
